// File: rtl/button_bounce_emulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_bounce_emulator_pkg
//  Description : Shared types and constants for the bouncy-contact emulator
//                and its LFSR helper.
//  Revision    : 1.0  initial release
// ============================================================================
package button_bounce_emulator_pkg;

    // Emulator control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Galois feedback taps for a maximal-length 16-bit right-shift LFSR
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // One LFSR step: shift right, fold the taps in when bit 0 falls out
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_bounce_emulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_bounce_emulator_if
//  Description : Command handshake and contact outputs of the emulator.
//                master = command source, slave = emulator.
//  Revision    : 1.0  initial release
// ============================================================================
interface button_bounce_emulator_if;
    logic cmd_valid;
    logic cmd_level;
    logic cmd_ready;
    logic b_out;
    logic busy;
    logic done;

    modport master (
        output cmd_valid,
        output cmd_level,
        input  cmd_ready,
        input  b_out,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_level,
        output cmd_ready,
        output b_out,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/button_bounce_emulator_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit Galois LFSR with enable; loads seed on reset.
//                Seed must be non-zero and is expected to be a constant.
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr16
    import button_bounce_emulator_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;

    // Advance one step per enable; a non-zero seed never reaches zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= seed;
        end else if (en) begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/button_bounce_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : button_bounce_emulator
//  Description : Turns a clean level command into a bouncy contact signal:
//                an odd burst of pseudo-random toggles with random tick gaps,
//                then a settle period ending in a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module button_bounce_emulator
    import button_bounce_emulator_pkg::*;
#(
    parameter int          BOUNCE_MAX   = 4,
    parameter int          GAP_MAX      = 4,
    parameter int          SETTLE_TICKS = 10,
    parameter logic        IDLE_LEVEL   = 1'b0,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    button_bounce_emulator_if.slave       bus
);

    // Remaining toggles reach 2*BOUNCE_MAX-1; gap reaches GAP_MAX
    localparam int TW = $clog2(2 * BOUNCE_MAX);
    localparam int GW = $clog2(GAP_MAX + 1);
    localparam int SW = $clog2(SETTLE_TICKS + 1);

    localparam logic [7:0] c_k_mask = 8'(BOUNCE_MAX - 1);
    localparam logic [7:0] c_g_mask = 8'(GAP_MAX - 1);

    state_t         r_state;
    logic           r_b_out;
    logic           r_done;
    logic [TW-1:0]  r_toggles;
    logic [GW-1:0]  r_gap;
    logic [SW-1:0]  r_settle;

    logic [15:0]    w_lfsr;
    logic           w_accept;
    logic           w_toggle;
    logic [7:0]     w_k;
    logic [8:0]     w_gap_sum;

    assign w_accept  = bus.cmd_valid && (r_state == ST_IDLE);
    // A zero gap marks the untimed first toggle right after acceptance
    assign w_toggle  = (r_state == ST_BOUNCE) &&
                       ((r_gap == '0) || (tick && (r_gap == GW'(1))));
    assign w_k       = w_lfsr[7:0] & c_k_mask;
    assign w_gap_sum = {1'b0, w_lfsr[15:8] & c_g_mask} + 9'd1;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (w_accept || w_toggle),
        .seed (SEED),
        .q    (w_lfsr)
    );

    // Control FSM: acceptance, timed toggling and settle countdown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_b_out   <= IDLE_LEVEL;
            r_done    <= 1'b0;
            r_toggles <= '0;
            r_gap     <= '0;
            r_settle  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (bus.cmd_level == r_b_out) begin
                            r_done <= 1'b1;
                        end else begin
                            // Odd toggle count guarantees b_out ends at the target
                            r_toggles <= TW'({w_k, 1'b1});
                            r_gap     <= '0;
                            r_state   <= ST_BOUNCE;
                        end
                    end
                end
                ST_BOUNCE: begin
                    if (w_toggle) begin
                        r_b_out <= ~r_b_out;
                        if (r_toggles == TW'(1)) begin
                            r_settle <= SW'(SETTLE_TICKS);
                            r_state  <= ST_SETTLE;
                        end else begin
                            r_toggles <= r_toggles - TW'(1);
                            r_gap     <= GW'(w_gap_sum);
                        end
                    end else if (tick) begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (tick) begin
                        if (r_settle == SW'(1)) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_settle <= r_settle - SW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.b_out     = r_b_out;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_button_bounce_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_bounce_emulator
//  Description : Directed bench for button_bounce_emulator: a default-param
//                instance plus a BOUNCE_MAX=1/GAP_MAX=1/SETTLE_TICKS=4 one.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_button_bounce_emulator;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick_d = 1'b0;
    logic tick_s = 1'b0;
    int   cnt_d = 0;
    int   cnt_s = 0;

    int checks = 0;
    int errors = 0;

    // Measured transition
    int   edges, first_cyc, settle;
    int   gaps[16];
    logic final_lvl;
    bit   got_done;
    logic done_after, ready_after;

    // Expected transition from the golden LFSR model
    logic [15:0] m_lfsr = 16'hACE1;
    int          exp_edges;
    int          exp_gaps[16];

    button_bounce_emulator_if if_d ();
    button_bounce_emulator_if if_s ();

    button_bounce_emulator #(
        .BOUNCE_MAX(4), .GAP_MAX(4), .SETTLE_TICKS(10),
        .IDLE_LEVEL(1'b0), .SEED(16'hACE1)
    ) u_dut_d (.clk(clk), .rst(rst), .tick(tick_d), .bus(if_d));

    button_bounce_emulator #(
        .BOUNCE_MAX(1), .GAP_MAX(1), .SETTLE_TICKS(4),
        .IDLE_LEVEL(1'b0), .SEED(16'hACE1)
    ) u_dut_s (.clk(clk), .rst(rst), .tick(tick_s), .bus(if_s));

    always #5 clk = ~clk;

    // Ticks: every 5 clk for the default instance, every 10 clk for the small one
    initial begin
        forever begin
            @(negedge clk);
            tick_d = (cnt_d == 4);
            cnt_d  = (cnt_d == 4) ? 0 : cnt_d + 1;
            tick_s = (cnt_s == 9);
            cnt_s  = (cnt_s == 9) ? 0 : cnt_s + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic get_b(input int which);
        return (which == 0) ? if_d.b_out : if_s.b_out;
    endfunction

    function automatic logic get_done(input int which);
        return (which == 0) ? if_d.done : if_s.done;
    endfunction

    function automatic logic get_ready(input int which);
        return (which == 0) ? if_d.cmd_ready : if_s.cmd_ready;
    endfunction

    task automatic set_cmd(input int which, input logic v, input logic l);
        if (which == 0) begin
            if_d.cmd_valid = v;
            if_d.cmd_level = l;
        end else begin
            if_s.cmd_valid = v;
            if_s.cmd_level = l;
        end
    endtask

    // Expected edge count and gaps for a level-changing command (default instance)
    task automatic model_transition();
        int k;
        k = int'(m_lfsr[7:0]) & 3;
        m_lfsr = lfsr_next(m_lfsr);
        exp_edges = 2 * k + 1;
        for (int i = 0; i < exp_edges; i++) begin
            if (i < exp_edges - 1) exp_gaps[i] = 1 + (int'(m_lfsr[15:8]) & 3);
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    // Issue one command and record edges (cycles/ticks) until done or timeout
    task automatic run_cmd(input int which, input logic lvl, input bit poke);
        int   ticks_since;
        int   cyc;
        logic prev;
        logic t;
        bit   poked;
        bit   poke_active;
        edges = 0; first_cyc = -1; settle = -1; got_done = 0;
        ticks_since = 0; cyc = 0; poked = 0; poke_active = 0;
        done_after = 1'bx; ready_after = 1'bx;
        @(negedge clk);
        set_cmd(which, 1'b1, lvl);
        prev = get_b(which);
        @(posedge clk);
        #1;
        set_cmd(which, 1'b0, lvl);
        for (int i = 0; i < 3000 && !got_done; i++) begin
            @(posedge clk);
            t = (which == 0) ? tick_d : tick_s;
            cyc++;
            #1;
            if (t) ticks_since++;
            if (get_b(which) !== prev) begin
                if (edges == 0) first_cyc = cyc;
                else if (edges <= 16) gaps[edges-1] = ticks_since;
                edges++;
                ticks_since = 0;
                prev = get_b(which);
            end
            if (get_done(which) === 1'b1) begin
                got_done = 1;
                settle = ticks_since;
            end
            if (poke_active) begin
                set_cmd(which, 1'b0, lvl);
                poke_active = 0;
            end else if (poke && !poked && edges >= 1 && !got_done) begin
                set_cmd(which, 1'b1, ~lvl);
                poked = 1;
                poke_active = 1;
            end
        end
        set_cmd(which, 1'b0, lvl);
        final_lvl = get_b(which);
        if (got_done) begin
            @(posedge clk);
            #1;
            done_after  = get_done(which);
            ready_after = get_ready(which);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (if_d.b_out !== 1'b0) begin errors++; $display("FAIL reset_in_b_out: got %b want 0", if_d.b_out); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (if_d.b_out !== 1'b0) begin errors++; $display("FAIL reset_b_out: got %b want 0", if_d.b_out); end
        checks++; if (if_d.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", if_d.cmd_ready); end
        checks++; if (if_d.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", if_d.busy); end
        checks++; if (if_d.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", if_d.done); end
        checks++; if (if_s.b_out !== 1'b0 || if_s.cmd_ready !== 1'b1 || if_s.busy !== 1'b0 || if_s.done !== 1'b0) begin
            errors++; $display("FAIL reset_small: got b=%b rdy=%b busy=%b done=%b want 0 1 0 0",
                               if_s.b_out, if_s.cmd_ready, if_s.busy, if_s.done);
        end
    endtask

    // First command after reset: k=1 from 16'hACE1, gaps 3 then 2
    task automatic test_first_transition(input string tag);
        run_cmd(0, 1'b1, 0);
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", tag, got_done); end
        checks++; if (first_cyc !== 1) begin errors++; $display("FAIL %s_first_edge: got %0d want 1", tag, first_cyc); end
        checks++; if (edges !== 3) begin errors++; $display("FAIL %s_edges: got %0d want 3", tag, edges); end
        checks++; if (gaps[0] !== 3 || gaps[1] !== 2) begin errors++; $display("FAIL %s_gaps: got %0d,%0d want 3,2", tag, gaps[0], gaps[1]); end
        checks++; if (settle !== 10) begin errors++; $display("FAIL %s_settle: got %0d want 10", tag, settle); end
        checks++; if (final_lvl !== 1'b1) begin errors++; $display("FAIL %s_final: got %b want 1", tag, final_lvl); end
        checks++; if (done_after !== 1'b0 || ready_after !== 1'b1) begin
            errors++; $display("FAIL %s_done_pulse: got done=%b ready=%b want 0 1", tag, done_after, ready_after);
        end
        model_transition();
    endtask

    task automatic test_small_params();
        run_cmd(1, 1'b1, 0);
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL small_done: got %b want 1", got_done); end
        checks++; if (first_cyc !== 1) begin errors++; $display("FAIL small_first_edge: got %0d want 1", first_cyc); end
        checks++; if (edges !== 1) begin errors++; $display("FAIL small_edges: got %0d want 1", edges); end
        checks++; if (settle !== 4) begin errors++; $display("FAIL small_settle: got %0d want 4", settle); end
        checks++; if (final_lvl !== 1'b1) begin errors++; $display("FAIL small_final: got %b want 1", final_lvl); end
    endtask

    task automatic test_random_commands();
        logic lvl;
        for (int n = 0; n < 50; n++) begin
            lvl = (n % 2 == 0) ? 1'b0 : 1'b1;
            repeat ($urandom_range(0, 7)) @(negedge clk);
            model_transition();
            run_cmd(0, lvl, 0);
            checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL rnd%0d_done: got %b want 1", n, got_done); end
            checks++; if (edges !== exp_edges || edges % 2 != 1 || edges > 7) begin
                errors++; $display("FAIL rnd%0d_edges: got %0d want %0d", n, edges, exp_edges);
            end
            for (int i = 0; i < exp_edges - 1 && i < 16; i++) begin
                checks++; if (gaps[i] !== exp_gaps[i] || gaps[i] < 1 || gaps[i] > 4) begin
                    errors++; $display("FAIL rnd%0d_gap%0d: got %0d want %0d", n, i, gaps[i], exp_gaps[i]);
                end
            end
            checks++; if (settle !== 10) begin errors++; $display("FAIL rnd%0d_settle: got %0d want 10", n, settle); end
            checks++; if (final_lvl !== lvl) begin errors++; $display("FAIL rnd%0d_final: got %b want %b", n, final_lvl, lvl); end
        end
    endtask

    // b_out is 1 here; asking for 1 again must only pulse done
    task automatic test_no_change();
        @(negedge clk);
        set_cmd(0, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_cmd(0, 1'b0, 1'b1);
        m_lfsr = lfsr_next(m_lfsr);
        checks++; if (if_d.done !== 1'b1) begin errors++; $display("FAIL nochg_done: got %b want 1", if_d.done); end
        checks++; if (if_d.busy !== 1'b0 || if_d.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL nochg_busy: got busy=%b ready=%b want 0 1", if_d.busy, if_d.cmd_ready);
        end
        @(posedge clk); #1;
        checks++; if (if_d.done !== 1'b0 || if_d.b_out !== 1'b1 || if_d.busy !== 1'b0) begin
            errors++; $display("FAIL nochg_after: got done=%b b=%b busy=%b want 0 1 0", if_d.done, if_d.b_out, if_d.busy);
        end
    endtask

    task automatic test_ignored_cmd();
        model_transition();
        run_cmd(0, 1'b0, 1);
        checks++; if (edges !== exp_edges) begin errors++; $display("FAIL ign_edges: got %0d want %0d", edges, exp_edges); end
        for (int i = 0; i < exp_edges - 1 && i < 16; i++) begin
            checks++; if (gaps[i] !== exp_gaps[i]) begin
                errors++; $display("FAIL ign_gap%0d: got %0d want %0d", i, gaps[i], exp_gaps[i]);
            end
        end
        checks++; if (settle !== 10 || final_lvl !== 1'b0) begin
            errors++; $display("FAIL ign_end: got settle=%0d final=%b want 10 0", settle, final_lvl);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_cmd(0, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_cmd(0, 1'b0, 1'b1);
        @(posedge clk); #1;
        checks++; if (if_d.b_out !== 1'b1 || if_d.busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got b=%b busy=%b want 1 1", if_d.b_out, if_d.busy);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (if_d.b_out !== 1'b0 || if_d.busy !== 1'b0 || if_d.cmd_ready !== 1'b1 || if_d.done !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: got b=%b busy=%b rdy=%b done=%b want 0 0 1 0",
                               if_d.b_out, if_d.busy, if_d.cmd_ready, if_d.done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_lfsr = 16'hACE1;
        test_first_transition("rerun");
    endtask

    initial begin
        set_cmd(0, 1'b0, 1'b0);
        set_cmd(1, 1'b0, 1'b0);
        test_reset();
        test_first_transition("first");
        test_small_params();
        test_random_commands();
        test_no_change();
        test_ignored_cmd();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_bounce_emulator.md
# button_bounce_emulator

Stimulus source for the button-sensor chain: takes a clean level command and drives a single-bit output that imitates a mechanical contact, with a pseudo-random burst of bounce edges, randomised gaps and a settle period. It is the transmitting end of the debouncer's input. `b_out` connects where a physical button would be, so the debouncer and everything downstream can be exercised on the board and in simulation without hand presses. All timing runs on a slow tick enable supplied by the existing frequency divider, and the whole block sits in the system clock domain.

## Interface
Parameters:
- `BOUNCE_MAX`, 4: maximum bounce pairs per transition; power of two, 1..256.
- `GAP_MAX`, 4: maximum ticks between bounce edges; power of two, 1..256.
- `SETTLE_TICKS`, 10: ticks `b_out` is held stable after the last edge before `done`; ≥1.
- `IDLE_LEVEL`, 1'b0: `b_out` level after reset (released button).
- `SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  single-cycle timing enable, for example 1 kHz.
- `cmd_valid`  in  1  new target level offered.
- `cmd_level`  in  1  target contact level.
- `cmd_ready`  out  1  command accepted this cycle when `cmd_valid` and `cmd_ready` are both high.
- `b_out`  out  1  emulated bouncy contact.
- `busy`  out  1  transition in progress.
- `done`  out  1  one-cycle pulse when `b_out` is settled at the target.

## Operation
- State machine `IDLE`, `BOUNCE`, `SETTLE`. `cmd_ready = (state == IDLE)`. `busy = !cmd_ready`.
- LFSR: 16-bit Galois, right-shift, feedback mask 16'hB400. It advances exactly once at each acceptance and once at each toggle in `BOUNCE`. It never reaches zero.
- Acceptance in `IDLE`:
  - If `cmd_level == b_out`: stay in `IDLE` and pulse `done` on the next cycle. No edges are produced.
  - Otherwise: latch the target and set k = `lfsr[7:0] & (BOUNCE_MAX-1)`, using the pre-advance LFSR value. Remaining toggles = 2k+1. Go to `BOUNCE`.
- `BOUNCE`:
  - The first toggle happens on the cycle after acceptance and is not gated by `tick`.
  - After each toggle except the last, load the gap counter with g = 1 + (`lfsr[15:8]` & (GAP_MAX-1)), using the LFSR value current at that toggle, before it advances.
  - Decrement the gap counter on each `tick`. When a `tick` arrives with the counter at 1, toggle `b_out`.
  - After the (2k+1)th toggle, load the settle counter with `SETTLE_TICKS` and go to `SETTLE`.
  - The toggle count is always odd, so the final `b_out` equals the target.
- `SETTLE`:
  - Decrement on each `tick`.
  - A `tick` with the counter at 1 sends the block to `IDLE` and raises `done` for exactly one cycle, coincident with `cmd_ready` rising.
- `cmd_valid` while `busy` is ignored. Commands are not queued and the command source must hold them.
- `tick` in the acceptance cycle does not count toward any gap.
- Counter widths are sized from the parameters with $clog2. No wrap is possible because counters only load values ≥1.

## Timing
- Reset values: `b_out = IDLE_LEVEL`, `cmd_ready = 1`, `busy = 0`, `done = 0`, LFSR = `SEED`, state `IDLE`, counters 0.
- Reset asserted mid-transition forces these values immediately (asynchronous) and drops the transition. No `done` is produced.
- Edge latency: first `b_out` edge 1 clk after acceptance. Subsequent edges land on the clk after the qualifying `tick`.
- Total transition span: 1 clk + Σg over the 2k gaps, in ticks, + `SETTLE_TICKS` ticks.
- No-change command: `done` 1 clk after acceptance, and `cmd_ready` never drops.
- Next command can be accepted in the same cycle that `done` is high.

## Structure
- Shared package or include, alongside the existing modules include:
  - state encoding `ST_IDLE`, `ST_BOUNCE`, `ST_SETTLE`;
  - constant `LFSR_MASK = 16'hB400`.
- One sub-module, `lfsr16`, with ports `clk`, `rst`, `en`, `seed`, `q`. It is reusable by other stimulus blocks.
- Top-level board wrapper: the existing frequency divider supplies `tick`, and `b_out` feeds the button debouncer.

## Test plan
- Reset release with `IDLE_LEVEL=0` → `b_out=0`, `cmd_ready=1`, `busy=0`, `done=0`.
- `BOUNCE_MAX=1`, `GAP_MAX=1`, `SETTLE_TICKS=4`, `tick` every 10 clk, `cmd_level=1` accepted at cycle t → `b_out` rises at t+1 with exactly one edge, and `done` pulses after the 4th subsequent tick.
- Defaults, 50 random commands alternating 1/0:
  - edge count per transition is odd and ≤ 7;
  - every gap is 1..4 ticks;
  - final `b_out` equals target;
  - edge times match a golden LFSR model seeded with 16'hACE1.
- `cmd_level` equal to current `b_out` → no edges, `done` 1 clk later, and `busy` stays 0.
- `cmd_valid` pulsed during `BOUNCE` → ignored; the edge sequence is unchanged versus a run without it.
- `rst` low mid-`BOUNCE` with `b_out=1` → `b_out=0` asynchronously. After release, the LFSR restarts from `SEED` and the next transition repeats the first-run pattern.
